mc_control_fsm: RTL and testbench

Multicycle main controller for the MIPS datapath. It sequences the shared ALU, the PC, the IR, the register file and the unified memory through the fetch, decode, execute, memory and writeback phases. Instruction fields are decoded from the IR. The block drives the mux selects, write strobes and the 4-bit ALU operation code (ALUOP_* encodings from aluop_def.v), and it handshakes with a variable-latency memory.

---
 rtl/mc_control_fsm.sv | 258 +++++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/memory/writeback
// and handshakes with a variable-latency memory. Optional HALT trap: MC_CTRL_ILLEGAL_TRAP_EN.
`ifndef ALUOP_ADD
`define ALUOP_ADD  4'd0
`define ALUOP_ADDU 4'd1
`define ALUOP_SUB  4'd2
`define ALUOP_SUBU 4'd3
`define ALUOP_AND  4'd4
`define ALUOP_OR   4'd5
`define ALUOP_XOR  4'd6
`define ALUOP_NOR  4'd7
`define ALUOP_SLT  4'd8
`define ALUOP_SLTU 4'd9
`define ALUOP_SLLV 4'd10
`define ALUOP_SRLV 4'd11
`define ALUOP_SRAV 4'd12
`endif

module mc_control_fsm #(
  parameter int ALUOP_W = 4,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ack,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               ir_we,
  output logic               pc_we,
  output logic [1:0]         pc_src,
  output logic [1:0]         alu_src_a,
  output logic [2:0]         alu_src_b,
  output logic               ext_zero,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               reg_we,
  output logic [1:0]         reg_dst,
  output logic [1:0]         wb_sel,
  output logic               instr_done,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    S_IF, S_ID, S_EX_R, S_EX_I, S_EX_MA, S_MEM_RD, S_MEM_WR,
    S_WB_R, S_WB_I, S_WB_MEM, S_BR, S_JMP, S_HALT
  } state_t;

  localparam logic [ALUOP_W-1:0] OP_ADD  = ALUOP_W'(`ALUOP_ADD);
  localparam logic [ALUOP_W-1:0] OP_ADDU = ALUOP_W'(`ALUOP_ADDU);
  localparam logic [ALUOP_W-1:0] OP_SUB  = ALUOP_W'(`ALUOP_SUB);
  localparam logic [ALUOP_W-1:0] OP_SUBU = ALUOP_W'(`ALUOP_SUBU);
  localparam logic [ALUOP_W-1:0] OP_AND  = ALUOP_W'(`ALUOP_AND);
  localparam logic [ALUOP_W-1:0] OP_OR   = ALUOP_W'(`ALUOP_OR);
  localparam logic [ALUOP_W-1:0] OP_XOR  = ALUOP_W'(`ALUOP_XOR);
  localparam logic [ALUOP_W-1:0] OP_NOR  = ALUOP_W'(`ALUOP_NOR);
  localparam logic [ALUOP_W-1:0] OP_SLT  = ALUOP_W'(`ALUOP_SLT);
  localparam logic [ALUOP_W-1:0] OP_SLTU = ALUOP_W'(`ALUOP_SLTU);
  localparam logic [ALUOP_W-1:0] OP_SLLV = ALUOP_W'(`ALUOP_SLLV);
  localparam logic [ALUOP_W-1:0] OP_SRLV = ALUOP_W'(`ALUOP_SRLV);
  localparam logic [ALUOP_W-1:0] OP_SRAV = ALUOP_W'(`ALUOP_SRAV);

  localparam logic [5:0] OPC_R = 6'h00, OPC_J = 6'h02, OPC_JAL = 6'h03, OPC_BEQ = 6'h04,
                         OPC_BNE = 6'h05, OPC_ADDI = 6'h08, OPC_ADDIU = 6'h09,
                         OPC_SLTI = 6'h0A, OPC_ANDI = 6'h0C, OPC_ORI = 6'h0D,
                         OPC_LW = 6'h23, OPC_SW = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_SLLV = 6'h04,
                         FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR = 6'h08;

  state_t state_q, state_next;

  // R-type funct decode; r_ok marks every funct the controller implements, JR included.
  logic               r_ok;
  logic [ALUOP_W-1:0] r_op;
  always_comb begin
    r_ok = 1'b1;
    r_op = OP_ADD;
    case (funct)
      6'h20:           r_op = OP_ADD;
      6'h21:           r_op = OP_ADDU;
      6'h22:           r_op = OP_SUB;
      6'h23:           r_op = OP_SUBU;
      6'h24:           r_op = OP_AND;
      6'h25:           r_op = OP_OR;
      6'h26:           r_op = OP_XOR;
      6'h27:           r_op = OP_NOR;
      6'h2A:           r_op = OP_SLT;
      6'h2B:           r_op = OP_SLTU;
      FN_SLL, FN_SLLV: r_op = OP_SLLV;
      FN_SRL, FN_SRLV: r_op = OP_SRLV;
      FN_SRA, FN_SRAV: r_op = OP_SRAV;
      FN_JR:           r_op = OP_ADD;
      default:         r_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_next;
  end

  assign state = state_q;

  always_comb begin
    state_next = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'd0;
    alu_src_a  = 2'd0;
    alu_src_b  = 3'd0;
    ext_zero   = 1'b0;
    alu_op     = OP_ADD;
    reg_we     = 1'b0;
    reg_dst    = 2'd0;
    wb_sel     = 2'd0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_IF: begin
        mem_req   = 1'b1;
        alu_src_b = 3'd1;
        if (mem_ack) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          state_next = S_ID;
        end
      end
      S_ID: begin
        alu_src_b = 3'd3;
        case (opcode)
          OPC_R: begin
            if (!r_ok)               state_next = S_IF;
            else if (funct == FN_JR) state_next = S_JMP;
            else                     state_next = S_EX_R;
          end
          OPC_J, OPC_JAL:                                   state_next = S_JMP;
          OPC_LW, OPC_SW:                                   state_next = S_EX_MA;
          OPC_BEQ, OPC_BNE:                                 state_next = S_BR;
          OPC_ADDI, OPC_ADDIU, OPC_ANDI, OPC_ORI, OPC_SLTI: state_next = S_EX_I;
          default:                                          state_next = S_IF;
        endcase
        // Anything that fell through to IF above is an undecodable instruction.
        if (state_next == S_IF) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          state_next = S_HALT;
`else
          instr_done = 1'b1;
`endif
        end
      end
      S_EX_R: begin
        alu_op = r_op;
        if (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA) begin
          alu_src_a = 2'd2;
          alu_src_b = 3'd4;
        end else if (funct == FN_SLLV || funct == FN_SRLV || funct == FN_SRAV) begin
          alu_src_a = 2'd2;
          alu_src_b = 3'd5;
        end else begin
          alu_src_a = 2'd1;
        end
        state_next = S_WB_R;
      end
      S_EX_I: begin
        alu_src_a = 2'd1;
        alu_src_b = 3'd2;
        ext_zero  = (opcode == OPC_ANDI) || (opcode == OPC_ORI);
        case (opcode)
          OPC_ADDIU: alu_op = OP_ADDU;
          OPC_ANDI:  alu_op = OP_AND;
          OPC_ORI:   alu_op = OP_OR;
          OPC_SLTI:  alu_op = OP_SLT;
          default:   alu_op = OP_ADD;
        endcase
        state_next = S_WB_I;
      end
      S_EX_MA: begin
        alu_src_a  = 2'd1;
        alu_src_b  = 3'd2;
        state_next = (opcode == OPC_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ack) state_next = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ack) begin
          instr_done = 1'b1;
          state_next = S_IF;
        end
      end
      S_WB_R, S_WB_I, S_WB_MEM: begin
        reg_we     = 1'b1;
        reg_dst    = (state_q == S_WB_R) ? 2'd1 : 2'd0;
        wb_sel     = (state_q == S_WB_MEM) ? 2'd1 : 2'd0;
        instr_done = 1'b1;
        state_next = S_IF;
      end
      S_BR: begin
        alu_src_a  = 2'd1;
        alu_op     = OP_SUB;
        pc_src     = 2'd1;
        pc_we      = (opcode == OPC_BNE) ? ~zero : zero;
        instr_done = 1'b1;
        state_next = S_IF;
      end
      S_JMP: begin
        pc_we      = 1'b1;
        instr_done = 1'b1;
        state_next = S_IF;
        if (opcode == OPC_JAL) begin
          pc_src  = 2'd2;
          reg_we  = 1'b1;
          reg_dst = 2'd2;
          wb_sel  = 2'd2;
        end else if (opcode == OPC_J) begin
          pc_src = 2'd2;
        end else begin
          pc_src = 2'd3;
        end
      end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      S_HALT: illegal = 1'b1;
`endif
      default: state_next = S_IF;
    endcase
    // Reset forces every output quiet, dropping any outstanding memory request.
    if (rst) begin
      state_next = S_IF;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = 2'd0;
      alu_src_a  = 2'd0;
      alu_src_b  = 3'd0;
      ext_zero   = 1'b0;
      alu_op     = '0;
      reg_we     = 1'b0;
      reg_dst    = 2'd0;
      wb_sel     = 2'd0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: instruction vector table through a scoreboard queue,
// plus hand sequences for reset abort, memory wait states and illegal opcodes.
module tb_mc_control_fsm;

  localparam logic [3:0] A_ADD = 4'd0, A_ADDU = 4'd1, A_SUB = 4'd2, A_AND = 4'd4,
                         A_OR = 4'd5, A_NOR = 4'd7, A_SLT = 4'd8, A_SLTU = 4'd9,
                         A_SLLV = 4'd10, A_SRLV = 4'd11, A_SRAV = 4'd12, A_XOR = 4'd6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ack = 1'b0;
  logic       mem_req, mem_we, iord, ir_we, pc_we, ext_zero, reg_we, instr_done, illegal;
  logic [1:0] pc_src, alu_src_a, reg_dst, wb_sel;
  logic [2:0] alu_src_b;
  logic [3:0] alu_op, state;

  int checks = 0;
  int errors = 0;
  int iord_cnt;
  int illegal_cnt = 0;
  int abort_reg_we = 0;
  bit abort_watch = 0;

  mc_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
    .alu_op(alu_op), .reg_we(reg_we), .reg_dst(reg_dst), .wb_sel(wb_sel),
    .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (abort_watch && reg_we) abort_reg_we++;

  // Packed result per instruction:
  // {cycles, post-decode state, alu_op, src_a, src_b, ext_zero, last state, reg_we, reg_dst, wb_sel, pc_we, pc_src}
  function automatic logic [29:0] mk(input int cyc, input logic [3:0] ex_st, input logic [3:0] op,
                                     input logic [1:0] a, input logic [2:0] b, input logic ez,
                                     input logic [3:0] last_st, input logic rwe, input logic [1:0] dst,
                                     input logic [1:0] wb, input logic pwe, input logic [1:0] psrc);
    return {4'(cyc), ex_st, op, a, b, ez, last_st, rwe, dst, wb, pwe, psrc};
  endfunction

  function automatic logic [23:0] bundle();
    return {mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b, ext_zero,
            alu_op, reg_we, reg_dst, wb_sel, instr_done, illegal};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Called at posedge+1 with state==IF; returns at posedge+1 after the instruction's last cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int if_w, input int mem_w, output logic [29:0] got);
    int cyc = 0;
    int wait_cnt = 0;
    bit done = 0;
    bit prev_stall = 0;
    logic [3:0] prev_st = 4'd0;
    logic [23:0] prev_b = '0;
    logic [3:0] ex_st = 0, ex_op = 0, last_st = 0;
    logic [1:0] ex_a = 0, l_dst = 0, l_wb = 0, l_psrc = 0;
    logic [2:0] ex_b = 0;
    logic ex_ez = 0, l_rwe = 0, l_pwe = 0;
    opcode = op; funct = fn; zero = z;
    iord_cnt = 0;
    while (!done && cyc < 40) begin
      mem_ack = mem_req && (wait_cnt >= ((state == 4'd0) ? if_w : mem_w));
      @(negedge clk);
      cyc++;
      if (illegal) illegal_cnt++;
      if (mem_req && iord) iord_cnt++;
      if (prev_stall && mem_req && !mem_ack) check("stall_stable", 32'(bundle()), 32'(prev_b));
      if (prev_st == 4'd1 && state != 4'd1) begin
        ex_st = state; ex_op = alu_op; ex_a = alu_src_a; ex_b = alu_src_b; ex_ez = ext_zero;
      end
      if (instr_done) begin
        done = 1; last_st = state; l_rwe = reg_we; l_dst = reg_dst; l_wb = wb_sel;
        l_pwe = pc_we; l_psrc = pc_src;
      end
      prev_stall = mem_req && !mem_ack;
      prev_b = bundle();
      prev_st = state;
      if (mem_req && !mem_ack) wait_cnt++; else wait_cnt = 0;
      @(posedge clk); #1;
    end
    mem_ack = 0;
    if (!done) begin
      errors++; checks++;
      $display("FAIL instr_timeout op=%0h fn=%0h got=no_done expected=done", op, fn);
    end
    got = {4'(cyc), ex_st, ex_op, ex_a, ex_b, ex_ez, last_st, l_rwe, l_dst, l_wb, l_pwe, l_psrc};
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    bit          rand_z;
    int          if_w;
    int          mem_w;
    logic [29:0] exp;
  } vec_t;

  vec_t vecs[26];
  logic [29:0] exp_q[$];

  initial begin
    logic [29:0] got, e;
    vecs[0]  = '{6'h00, 6'h20, 0, 1, 0, 0, mk(4, 2, A_ADD, 1, 0, 0, 7, 1, 1, 0, 0, 0)};
    vecs[1]  = '{6'h00, 6'h22, 0, 1, 0, 0, mk(4, 2, A_SUB, 1, 0, 0, 7, 1, 1, 0, 0, 0)};
    vecs[2]  = '{6'h00, 6'h27, 0, 1, 0, 0, mk(4, 2, A_NOR, 1, 0, 0, 7, 1, 1, 0, 0, 0)};
    vecs[3]  = '{6'h00, 6'h2B, 0, 1, 0, 0, mk(4, 2, A_SLTU, 1, 0, 0, 7, 1, 1, 0, 0, 0)};
    vecs[4]  = '{6'h00, 6'h00, 0, 1, 0, 0, mk(4, 2, A_SLLV, 2, 4, 0, 7, 1, 1, 0, 0, 0)};
    vecs[5]  = '{6'h00, 6'h03, 0, 1, 0, 0, mk(4, 2, A_SRAV, 2, 4, 0, 7, 1, 1, 0, 0, 0)};
    vecs[6]  = '{6'h00, 6'h04, 0, 1, 0, 0, mk(4, 2, A_SLLV, 2, 5, 0, 7, 1, 1, 0, 0, 0)};
    vecs[7]  = '{6'h00, 6'h06, 0, 1, 0, 0, mk(4, 2, A_SRLV, 2, 5, 0, 7, 1, 1, 0, 0, 0)};
    vecs[8]  = '{6'h08, 6'h00, 0, 1, 0, 0, mk(4, 3, A_ADD, 1, 2, 0, 8, 1, 0, 0, 0, 0)};
    vecs[9]  = '{6'h09, 6'h11, 0, 1, 0, 0, mk(4, 3, A_ADDU, 1, 2, 0, 8, 1, 0, 0, 0, 0)};
    vecs[10] = '{6'h0C, 6'h00, 0, 1, 0, 0, mk(4, 3, A_AND, 1, 2, 1, 8, 1, 0, 0, 0, 0)};
    vecs[11] = '{6'h0D, 6'h25, 0, 1, 0, 0, mk(4, 3, A_OR, 1, 2, 1, 8, 1, 0, 0, 0, 0)};
    vecs[12] = '{6'h0A, 6'h00, 0, 1, 0, 0, mk(4, 3, A_SLT, 1, 2, 0, 8, 1, 0, 0, 0, 0)};
    vecs[13] = '{6'h23, 6'h00, 0, 1, 0, 0, mk(5, 4, A_ADD, 1, 2, 0, 9, 1, 0, 1, 0, 0)};
    vecs[14] = '{6'h2B, 6'h00, 0, 1, 0, 0, mk(4, 4, A_ADD, 1, 2, 0, 6, 0, 0, 0, 0, 0)};
    vecs[15] = '{6'h04, 6'h00, 1, 0, 0, 0, mk(3, 10, A_SUB, 1, 0, 0, 10, 0, 0, 0, 1, 1)};
    vecs[16] = '{6'h04, 6'h00, 0, 0, 0, 0, mk(3, 10, A_SUB, 1, 0, 0, 10, 0, 0, 0, 0, 1)};
    vecs[17] = '{6'h05, 6'h00, 0, 0, 0, 0, mk(3, 10, A_SUB, 1, 0, 0, 10, 0, 0, 0, 1, 1)};
    vecs[18] = '{6'h05, 6'h00, 1, 0, 0, 0, mk(3, 10, A_SUB, 1, 0, 0, 10, 0, 0, 0, 0, 1)};
    vecs[19] = '{6'h02, 6'h00, 0, 1, 0, 0, mk(3, 11, A_ADD, 0, 0, 0, 11, 0, 0, 0, 1, 2)};
    vecs[20] = '{6'h00, 6'h08, 0, 1, 0, 0, mk(3, 11, A_ADD, 0, 0, 0, 11, 0, 0, 0, 1, 3)};
    vecs[21] = '{6'h03, 6'h00, 0, 1, 0, 0, mk(3, 11, A_ADD, 0, 0, 0, 11, 1, 2, 2, 1, 2)};
    vecs[22] = '{6'h23, 6'h00, 0, 1, 0, 3, mk(8, 4, A_ADD, 1, 2, 0, 9, 1, 0, 1, 0, 0)};
    vecs[23] = '{6'h00, 6'h20, 0, 1, 2, 0, mk(6, 2, A_ADD, 1, 0, 0, 7, 1, 1, 0, 0, 0)};
    vecs[24] = '{6'h2B, 6'h00, 0, 1, 1, 2, mk(7, 4, A_ADD, 1, 2, 0, 6, 0, 0, 0, 0, 0)};
    vecs[25] = '{6'h00, 6'h26, 0, 1, 0, 0, mk(4, 2, A_XOR, 1, 0, 0, 7, 1, 1, 0, 0, 0)};

    // Reset: outputs quiet while rst is high, state IF once released.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'(bundle()), 32'd0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("reset_state", 32'(state), 32'd0);
    check("reset_if_req", 32'(mem_req), 32'd1);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      logic z;
      z = vecs[i].rand_z ? 1'($urandom_range(0, 1)) : vecs[i].z;
      exp_q.push_back(vecs[i].exp);
      run_instr(vecs[i].op, vecs[i].fn, z, vecs[i].if_w, vecs[i].mem_w, got);
      e = exp_q.pop_front();
      check($sformatf("vec%0d", i), 32'(got), 32'(e));
    end

    // LW with three wait cycles in MEM_RD: read request held for four cycles.
    exp_q.push_back(mk(8, 4, A_ADD, 1, 2, 0, 9, 1, 0, 1, 0, 0));
    run_instr(6'h23, 6'h00, 0, 0, 3, got);
    e = exp_q.pop_front();
    check("lw_wait_result", 32'(got), 32'(e));
    check("lw_wait_iord_cycles", 32'(iord_cnt), 32'd4);

    // Reset while an LW read is pending aborts it without a register write.
    opcode = 6'h23; funct = 6'h00;
    abort_watch = 1;
    for (int k = 0; k < 10 && state != 4'd5; k++) begin
      mem_ack = mem_req;
      @(posedge clk); #1;
    end
    mem_ack = 0;
    @(negedge clk);
    check("abort_in_mem_rd", 32'({state, mem_req, iord}), 32'({4'd5, 2'b11}));
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    check("abort_rst_outputs", 32'(bundle()), 32'd0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("abort_state_if", 32'(state), 32'd0);
    abort_watch = 0;
    check("abort_no_reg_we", 32'(abort_reg_we), 32'd0);
    @(posedge clk); #1;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    opcode = 6'h3F; funct = 6'h00;
    mem_ack = 1;
    @(posedge clk); #1;
    mem_ack = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("halt_c%0d", k), 32'({state, illegal, mem_req, ir_we, pc_we, reg_we, mem_we, instr_done}),
            32'({4'd12, 1'b1, 6'b0}));
    end
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("halt_cleared", 32'({state, illegal}), 32'({4'd0, 1'b0}));
    @(posedge clk); #1;
`else
    exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    run_instr(6'h3F, 6'h00, 0, 0, 0, got);
    e = exp_q.pop_front();
    check("illegal_opcode_nop", 32'(got), 32'(e));
    exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    run_instr(6'h00, 6'h3F, 0, 0, 0, got);
    e = exp_q.pop_front();
    check("illegal_funct_nop", 32'(got), 32'(e));
    check("illegal_never_set", 32'(illegal_cnt), 32'd0);
`endif

    // Following instruction still runs normally.
    exp_q.push_back(mk(4, 2, A_ADD, 1, 0, 0, 7, 1, 1, 0, 0, 0));
    run_instr(6'h00, 6'h20, 0, 0, 0, got);
    e = exp_q.pop_front();
    check("after_all_add", 32'(got), 32'(e));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
